// File: rtl/monkey_hit_detector.sv
// Per-pixel collision detector between the monkey sprite and scene objects.
// Produces per-frame collision levels, first-hit pulses, the edge code of the
// first floor/rope contact and the rope contact offset.
module monkey_hit_detector #(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_MARGIN   = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               monkeyDR,
  input  logic               floorDR,
  input  logic               ropesDR,
  input  logic               fruitsDR,
  input  logic               targetDR,
  input  logic               enemyDR,
  input  logic               ropeDR,
  output logic               collision_f_floor,
  output logic               collision_f_ropes,
  output logic               collision_f_fruits,
  output logic               collision_f_target,
  output logic               collision_f_enemy,
  output logic               collision_f_rope,
  output logic               SingleHit_floor,
  output logic               SingleHit_ropes,
  output logic               SingleHit_fruits,
  output logic               SingleHit_target,
  output logic               SingleHit_enemy,
  output logic [3:0]         HitEdgeCode,
  output logic signed [10:0] ropePixelX,
  output logic [10:0]        ropePixelY
);

  // Class index order: {rope, enemy, target, fruits, ropes, floor}
  localparam int unsigned FLOOR = 0;
  localparam int unsigned ROPE  = 5;

  localparam logic signed [11:0] MARGIN_S = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] X_HI_S   = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] Y_HI_S   = 12'(OBJECT_HEIGHT - EDGE_MARGIN);
  localparam logic signed [11:0] HALF_W_S = 12'(OBJECT_WIDTH / 2);

  logic [5:0]         raw;
  logic [5:0]         first_hit;
  logic               edge_event;
  logic               edge_first;
  logic signed [11:0] off_x;
  logic signed [11:0] off_y;
  logic signed [11:0] rope_off_x;

  logic [5:0]  hit_frame_d,  hit_frame_q;
  logic        edge_frame_d, edge_frame_q;
  logic [5:0]  collision_d,  collision_q;
  logic [4:0]  single_hit_d, single_hit_q;
  logic [3:0]  edge_code_d,  edge_code_q;
  logic [10:0] rope_x_d,     rope_x_q;
  logic [10:0] rope_y_d,     rope_y_q;

  // Coincidence detection, offsets and next-state for all flags and latches
  always_comb begin
    raw = {6{monkeyDR}} & {ropeDR, enemyDR, targetDR, fruitsDR, ropesDR, floorDR};

    off_x      = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
    off_y      = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
    rope_off_x = off_x - HALF_W_S;

    // A hit in the startOfFrame cycle is the first hit of the new frame
    first_hit   = raw & (~hit_frame_q | {6{startOfFrame}});
    hit_frame_d = (hit_frame_q & ~{6{startOfFrame}}) | raw;

    // Floor and rope share one "first contact" flag so the edge code is
    // latched once per frame by whichever of the two arrives first
    edge_event   = raw[FLOOR] | raw[ROPE];
    edge_first   = edge_event & (~edge_frame_q | startOfFrame);
    edge_frame_d = (edge_frame_q & ~startOfFrame) | edge_event;

    single_hit_d = first_hit[4:0];
    collision_d  = startOfFrame ? (hit_frame_q | raw) : collision_q;

    edge_code_d = edge_code_q;
    if (edge_first) begin
      edge_code_d = {off_x < MARGIN_S, off_y < MARGIN_S,
                     off_x >= X_HI_S,  off_y >= Y_HI_S};
    end

    rope_x_d = rope_x_q;
    rope_y_d = rope_y_q;
    if (first_hit[ROPE]) begin
      rope_x_d = rope_off_x[10:0];
      rope_y_d = off_y[10:0];
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_frame_q  <= '0;
      edge_frame_q <= 1'b0;
      collision_q  <= '0;
      single_hit_q <= '0;
      edge_code_q  <= '0;
      rope_x_q     <= '0;
      rope_y_q     <= '0;
    end else begin
      hit_frame_q  <= hit_frame_d;
      edge_frame_q <= edge_frame_d;
      collision_q  <= collision_d;
      single_hit_q <= single_hit_d;
      edge_code_q  <= edge_code_d;
      rope_x_q     <= rope_x_d;
      rope_y_q     <= rope_y_d;
    end
  end

  assign collision_f_floor  = collision_q[0];
  assign collision_f_ropes  = collision_q[1];
  assign collision_f_fruits = collision_q[2];
  assign collision_f_target = collision_q[3];
  assign collision_f_enemy  = collision_q[4];
  assign collision_f_rope   = collision_q[5];

  assign SingleHit_floor  = single_hit_q[0];
  assign SingleHit_ropes  = single_hit_q[1];
  assign SingleHit_fruits = single_hit_q[2];
  assign SingleHit_target = single_hit_q[3];
  assign SingleHit_enemy  = single_hit_q[4];

  assign HitEdgeCode = edge_code_q;
  assign ropePixelX  = $signed(rope_x_q);
  assign ropePixelY  = rope_y_q;

endmodule

// File: tb/tb_monkey_hit_detector.sv
// Directed, table-driven bench for monkey_hit_detector with topLeft = (100,200).
module tb_monkey_hit_detector;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [10:0]        pixelX, pixelY;
  logic signed [10:0] topLeftX, topLeftY;
  logic               monkeyDR;
  logic               floorDR, ropesDR, fruitsDR, targetDR, enemyDR, ropeDR;
  logic               collision_f_floor, collision_f_ropes, collision_f_fruits;
  logic               collision_f_target, collision_f_enemy, collision_f_rope;
  logic               SingleHit_floor, SingleHit_ropes, SingleHit_fruits;
  logic               SingleHit_target, SingleHit_enemy;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] ropePixelX;
  logic [10:0]        ropePixelY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monkey_hit_detector #(
    .OBJECT_WIDTH (32),
    .OBJECT_HEIGHT(32),
    .EDGE_MARGIN  (4)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .pixelX            (pixelX),
    .pixelY            (pixelY),
    .topLeftX          (topLeftX),
    .topLeftY          (topLeftY),
    .monkeyDR          (monkeyDR),
    .floorDR           (floorDR),
    .ropesDR           (ropesDR),
    .fruitsDR          (fruitsDR),
    .targetDR          (targetDR),
    .enemyDR           (enemyDR),
    .ropeDR            (ropeDR),
    .collision_f_floor (collision_f_floor),
    .collision_f_ropes (collision_f_ropes),
    .collision_f_fruits(collision_f_fruits),
    .collision_f_target(collision_f_target),
    .collision_f_enemy (collision_f_enemy),
    .collision_f_rope  (collision_f_rope),
    .SingleHit_floor   (SingleHit_floor),
    .SingleHit_ropes   (SingleHit_ropes),
    .SingleHit_fruits  (SingleHit_fruits),
    .SingleHit_target  (SingleHit_target),
    .SingleHit_enemy   (SingleHit_enemy),
    .HitEdgeCode       (HitEdgeCode),
    .ropePixelX        (ropePixelX),
    .ropePixelY        (ropePixelY)
  );

  // dr order {rope, enemy, target, fruits, ropes, floor}; single order {enemy..floor}
  typedef struct {
    logic        sof;
    logic [10:0] px;
    logic [10:0] py;
    logic        mon;
    logic [5:0]  dr;
    logic [4:0]  e_single;
    logic [5:0]  e_coll;
    logic [3:0]  e_edge;
    logic [10:0] e_rpx;
    logic [10:0] e_rpy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sof, input int px, input int py, input logic mon,
                     input logic [5:0] dr, input logic [4:0] s, input logic [5:0] c,
                     input logic [3:0] e, input logic [10:0] rx, input logic [10:0] ry);
    vec_t v;
    v.sof = sof; v.px = 11'(px); v.py = 11'(py); v.mon = mon; v.dr = dr;
    v.e_single = s; v.e_coll = c; v.e_edge = e; v.e_rpx = rx; v.e_rpy = ry;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sof, input logic [10:0] px, input logic [10:0] py,
                       input logic mon, input logic [5:0] dr);
    startOfFrame = sof;
    pixelX = px; pixelY = py; monkeyDR = mon;
    {ropeDR, enemyDR, targetDR, fruitsDR, ropesDR, floorDR} = dr;
  endtask

  task automatic check(input string name, input logic [4:0] s, input logic [5:0] c,
                       input logic [3:0] e, input logic [10:0] rx, input logic [10:0] ry);
    logic [4:0]  a_s;
    logic [5:0]  a_c;
    logic [10:0] a_rx;
    a_s  = {SingleHit_enemy, SingleHit_target, SingleHit_fruits, SingleHit_ropes, SingleHit_floor};
    a_c  = {collision_f_rope, collision_f_enemy, collision_f_target,
            collision_f_fruits, collision_f_ropes, collision_f_floor};
    a_rx = ropePixelX;
    checks += 5;
    if (a_s !== s) begin
      errors++;
      $display("FAIL %s single: got %b expected %b", name, a_s, s);
    end
    if (a_c !== c) begin
      errors++;
      $display("FAIL %s collision: got %b expected %b", name, a_c, c);
    end
    if (HitEdgeCode !== e) begin
      errors++;
      $display("FAIL %s edge: got %b expected %b", name, HitEdgeCode, e);
    end
    if (a_rx !== rx) begin
      errors++;
      $display("FAIL %s ropePixelX: got %h expected %h", name, a_rx, rx);
    end
    if (ropePixelY !== ry) begin
      errors++;
      $display("FAIL %s ropePixelY: got %h expected %h", name, ropePixelY, ry);
    end
  endtask

  initial begin
    // sof  px   py   mon dr         single    coll       edge     rpx      rpy
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0000, 11'h000, 11'd0);  // 0 idle frames
    add(0, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0000, 11'h000, 11'd0);
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0000, 11'h000, 11'd0);
    add(0, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0000, 11'h000, 11'd0);
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0000, 11'h000, 11'd0);
    add(0, 110, 231, 1, 6'b000001, 5'b00001, 6'b000000, 4'b0001, 11'h000, 11'd0);  // 5 floor bottom
    add(0, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0001, 11'h000, 11'd0);
    add(0, 111, 231, 1, 6'b000001, 5'b00000, 6'b000000, 4'b0001, 11'h000, 11'd0);  // 7 second hit
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000001, 4'b0001, 11'h000, 11'd0);  // 8 level up
    add(0, 0,   0,   0, 6'b000000, 5'b00000, 6'b000001, 4'b0001, 11'h000, 11'd0);
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000000, 4'b0001, 11'h000, 11'd0);  // 10 level drops
    add(0, 100, 200, 1, 6'b000001, 5'b00001, 6'b000000, 4'b1100, 11'h000, 11'd0);  // 11 TL corner
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000001, 4'b1100, 11'h000, 11'd0);
    add(0, 131, 231, 1, 6'b000001, 5'b00001, 6'b000001, 4'b0011, 11'h000, 11'd0);  // 13 BR corner
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b000001, 4'b0011, 11'h000, 11'd0);
    add(0, 105, 210, 1, 6'b100000, 5'b00000, 6'b000001, 4'b0000, 11'h7F5, 11'd10); // 15 rope left
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b100000, 4'b0000, 11'h7F5, 11'd10);
    add(0, 130, 205, 1, 6'b100000, 5'b00000, 6'b100000, 4'b0010, 11'h00E, 11'd5);  // 17 rope right
    add(1, 110, 210, 1, 6'b010000, 5'b10000, 6'b110000, 4'b0010, 11'h00E, 11'd5);  // 18 sof+enemy
    add(0, 111, 210, 1, 6'b010000, 5'b00000, 6'b110000, 4'b0010, 11'h00E, 11'd5);  // 19 enemy again
    add(0, 112, 210, 1, 6'b001100, 5'b01100, 6'b110000, 4'b0010, 11'h00E, 11'd5);  // 20 fruits+target
    add(0, 0,   0,   0, 6'b000000, 5'b00000, 6'b110000, 4'b0010, 11'h00E, 11'd5);
    add(1, 0,   0,   0, 6'b000000, 5'b00000, 6'b011100, 4'b0010, 11'h00E, 11'd5);  // 22 new frame

    resetN = 1'b0;
    topLeftX = 11'sd100;
    topLeftY = 11'sd200;
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    check("reset", '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sof, vecs[i].px, vecs[i].py, vecs[i].mon, vecs[i].dr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_single, vecs[i].e_coll,
            vecs[i].e_edge, vecs[i].e_rpx, vecs[i].e_rpy);
    end

    // Reset in the middle of a frame that already has a target hit
    drive(1'b0, 11'd110, 11'd210, 1'b1, 6'b001000);
    @(posedge clk);
    #1;
    check("pre_rst_target", 5'b01000, 6'b011100, 4'b0010, 11'h00E, 11'd5);
    drive(1'b0, '0, '0, 1'b0, '0);
    resetN = 1'b0;
    #1;
    check("rst_async", '0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d", i), '0, '0, '0, '0, '0);
    end
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", '0, '0, '0, '0, '0);
    drive(1'b0, 11'd110, 11'd210, 1'b1, 6'b001000);
    @(posedge clk);
    #1;
    check("post_rst_target", 5'b01000, '0, '0, '0, '0);
    drive(1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    check("post_rst_idle", '0, '0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monkey_hit_detector.md
# monkey_hit_detector

Per-pixel collision detector that feeds the monkey movement logic. It compares the monkey drawing request against each scene-object drawing request as the VGA scan passes, and produces per-class collision levels and once-per-frame hit pulses. For floor and rope hits it also produces the edge code and the rope contact offset. It sits between the object drawers / VGA scan counters and the monkey movement block. It takes the monkey's current top-left position as an input.

## Interface
- OBJECT_WIDTH, 32, monkey sprite width in pixels
- OBJECT_HEIGHT, 32, monkey sprite height in pixels
- EDGE_MARGIN, 4, edge band thickness in pixels used for HitEdgeCode

Clock and reset: clk, resetN — reset resetN, asynchronous, active-low; clock clk.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- pixelX, pixelY  in  11  current scan pixel
- topLeftX, topLeftY  in  11 signed  monkey top-left corner
- monkeyDR  in  1  monkey drawing request at current pixel
- floorDR, ropesDR, fruitsDR, targetDR, enemyDR, ropeDR  in  1 each  object drawing requests
- collision_f_floor/_ropes/_fruits/_target/_enemy/_rope  out  1 each  "class was hit during previous frame" level
- SingleHit_floor/_ropes/_fruits/_target/_enemy  out  1 each  first-hit-of-frame pulse
- HitEdgeCode  out  4  edge bits {Left, Top, Right, Bottom}
- ropePixelX  out  11  signed X offset of the rope contact from the monkey centre
- ropePixelY  out  11  Y offset of the rope contact from topLeftY

## Operation
- Coincidence: raw_k = monkeyDR & kDR, for each of the 6 classes, evaluated every cycle.
- Offsets, 12-bit signed:
  - offX = pixelX − topLeftX
  - offY = pixelY − topLeftY
- Per-frame flags hitFrame_k, one per class:
  - Cleared by startOfFrame.
  - Set by raw_k.
  - If startOfFrame and raw_k occur in the same cycle, the set wins: the hit counts as the first hit of the new frame.
- SingleHit_k (5 classes, no rope pulse):
  - Registered pulse, high exactly one cycle after the first raw_k of a frame.
  - "First" means hitFrame_k was clear, or startOfFrame occurs in the same cycle.
  - At most one pulse per class per frame.
- collision_f_k (6 classes):
  - Registered on the cycle of startOfFrame as (hitFrame_k | raw_k).
  - Held constant for the whole following frame.
- HitEdgeCode:
  - Latched on the first floor or rope coincidence of a frame. If both coincide on the same pixel, the floor event is the one latched.
  - Bit 3 = offX < EDGE_MARGIN.
  - Bit 2 = offY < EDGE_MARGIN.
  - Bit 1 = offX ≥ OBJECT_WIDTH − EDGE_MARGIN.
  - Bit 0 = offY ≥ OBJECT_HEIGHT − EDGE_MARGIN.
  - Signed compares; a negative offset sets the Left/Top bit.
  - Holds its value across frames until the next latch; it is not cleared at startOfFrame.
- ropePixelX / ropePixelY:
  - Latched on the first ropeDR coincidence of a frame.
  - ropePixelX = offX − OBJECT_WIDTH/2, truncated to 11-bit two's complement; bit 10 is the sign (negative = contact left of centre).
  - ropePixelY = offY truncated to 11 bits.
  - Hold until the next latch.
- Width rules: all subtractions use 12 bits. Saturation is unnecessary for a 640x480 screen.

## Timing
- Reset value of every output: 0. This includes HitEdgeCode = 4'b0000 and ropePixelX/Y = 0.
- Reset mid-frame: all flags and outputs clear immediately. No pulse is emitted after release for hits that occurred before reset. The first coincidence after release is treated as a first hit.
- SingleHit_k latency: 1 clk after the coincident pixel.
- HitEdgeCode and ropePixel latency: valid 1 clk after the coincident pixel, i.e. in the same cycle as SingleHit_floor.
- collision_f_k latency:
  - Changes only in the cycle after startOfFrame.
  - Reflects the previous full frame: one frame of latency. The movement block sampling it at the next startOfFrame therefore sees the frame before.
- Back-to-back coincidences in a frame: only the first one affects SingleHit, HitEdgeCode and ropePixel.
- startOfFrame asserted for multiple cycles: each cycle clears and resamples. This is legal but unsupported.

## Test plan
- Reset → every output is 0. Hold startOfFrame idle for 2 frames → all outputs stay 0.
- Floor, bottom edge (topLeft = (100,200), W = H = 32, margin 4):
  - Stimulus: monkeyDR & floorDR at pixel (110,231).
  - Next cycle: SingleHit_floor = 1 for 1 cycle; HitEdgeCode = 4'b0001.
  - A second floor hit at (111,231) in the same frame → no pulse.
  - Next startOfFrame → collision_f_floor = 1 for the whole frame.
  - A frame with no hit → collision_f_floor drops after the following startOfFrame.
- Floor, corner (same topLeft): hit at pixel (100,200) → HitEdgeCode = 4'b1100. Hit at pixel (131,231) → 4'b0011.
- Rope contact (same topLeft):
  - Hit at pixel (105,210) → ropePixelX = 11'h7F5 (−11), ropePixelY = 10, HitEdgeCode = 4'b0000; no SingleHit emitted.
  - Next frame, hit at pixel (130,205) → ropePixelX = 14.
- Same-cycle frame start:
  - startOfFrame coincident with monkeyDR & enemyDR → SingleHit_enemy pulses 1 cycle later.
  - A further enemy hit in the same frame → no pulse.
  - Simultaneous fruits and target hits → both pulses fire in the same cycle.
- Reset mid-frame:
  - Target hit, then resetN low for 3 cycles, then released.
  - All outputs are 0; no SingleHit_target appears.
  - A new target hit → SingleHit_target pulses.
